pipeline_stall_ctrl: RTL and testbench

- Central sequencer for the 5-stage pipeline's stage registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
- Each stage register is a write-enabled register with a bubble mux on its data input. This block drives every write-enable and bubble select from the hazard, memory-wait, multi-cycle-MDU and exception inputs.
- Owns the MDU busy timer, so no other block needs to count MDU cycles.

---
 rtl/pipeline_stall_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_ctrl.sv
// Stage-register sequencer for the 5-stage pipeline: write enables, bubble selects and the MDU busy timer.
// Optional stall-cycle statistics counter is built when PIPE_STALL_STATS_EN is defined.
module pipeline_stall_ctrl #(
   parameter int unsigned MDU_MUL_LAT = 4,
   parameter int unsigned MDU_DIV_LAT = 32,
   parameter int unsigned CNT_W       = 6
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_imem_ready,
   input  logic       i_dmem_ready,
   input  logic       i_load_use,
   input  logic       i_branch_taken,
   input  logic       i_mdu_start,
   input  logic       i_mdu_is_div,
   input  logic       i_exception,
   output logic [4:0] o_stage_we,
   output logic [4:0] o_stage_flush,
   output logic       o_mdu_busy,
   output logic       o_mdu_done,
   output logic       o_state
`ifdef PIPE_STALL_STATS_EN
   ,
   output logic [31:0] o_stall_cycles
`endif
);

   localparam int unsigned NSTAGE = 5;
   localparam int unsigned STAT_W = 32;
   localparam int unsigned ST_PC  = 0;
   localparam int unsigned ST_IF  = 1;
   localparam int unsigned ST_ID  = 2;
   localparam int unsigned ST_EX  = 3;

   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MDU_MUL_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(MDU_DIV_LAT - 1);

   typedef enum logic {
      RUN      = 1'b0,
      MDU_WAIT = 1'b1
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_next;
   logic               mdu_stall;
   logic               releasing;
   logic [NSTAGE-1:0]  rule_we;
   logic [NSTAGE-1:0]  rule_flush;

   // State register and MDU countdown
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Timer finished; the release cycle still waits for a pending data access
   assign releasing = (state == MDU_WAIT) && (cnt == '0);
   assign mdu_stall = ((state == RUN) && i_mdu_start) ||
                      ((state == MDU_WAIT) && (cnt != '0));

   // Next-state and counter
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      if (i_exception) begin
         state_next = RUN;
         cnt_next   = '0;
      end else begin
         case (state)
            RUN: begin
               if (i_mdu_start && i_dmem_ready) begin
                  state_next = MDU_WAIT;
                  cnt_next   = i_mdu_is_div ? DIV_LOAD : MUL_LOAD;
               end
            end
            MDU_WAIT: begin
               // Countdown keeps running under a dmem freeze and saturates at zero
               if (cnt != '0) begin
                  cnt_next = cnt - CNT_W'(1);
               end else if (i_dmem_ready) begin
                  state_next = RUN;
               end
            end
            default: begin
               state_next = RUN;
               cnt_next   = '0;
            end
         endcase
      end
   end

   // Prioritised stall/flush decode; only the highest active rule takes effect
   always_comb begin
      rule_we    = '1;
      rule_flush = '0;
      o_mdu_done = 1'b0;
      if (i_exception) begin
         rule_flush                = '1;
         rule_flush[ST_PC]         = 1'b0;
      end else if (!i_dmem_ready) begin
         rule_we                   = '0;
      end else if (mdu_stall) begin
         rule_we[ST_PC]            = 1'b0;
         rule_we[ST_IF]            = 1'b0;
         rule_we[ST_ID]            = 1'b0;
         rule_flush[ST_EX]         = 1'b1;
      end else begin
         o_mdu_done = releasing;
         if (i_branch_taken) begin
            rule_flush[ST_IF]      = 1'b1;
            rule_flush[ST_ID]      = 1'b1;
         end else if (i_load_use) begin
            rule_we[ST_PC]         = 1'b0;
            rule_we[ST_IF]         = 1'b0;
            rule_flush[ST_ID]      = 1'b1;
         end else if (!i_imem_ready) begin
            rule_we[ST_PC]         = 1'b0;
            rule_flush[ST_IF]      = 1'b1;
         end
      end
   end

   // A bubble is only inserted if the register actually loads it
   assign o_stage_we    = rule_we | rule_flush;
   assign o_stage_flush = rule_flush;
   assign o_mdu_busy    = (state == MDU_WAIT);
   assign o_state       = 1'(state);

`ifdef PIPE_STALL_STATS_EN
   logic [STAT_W-1:0] stall_cycles;

   // Cycles in which the PC is held
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles <= '0;
      end else if (!o_stage_we[ST_PC]) begin
         stall_cycles <= stall_cycles + STAT_W'(1);
      end
   end

   assign o_stall_cycles = stall_cycles;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: directed vector table, MDU corner sequences,
// and randomized traffic compared against a cycle-stamp reference model.
module tb_pipeline_stall_ctrl;

   localparam int unsigned MUL_LAT = 4;
   localparam int unsigned DIV_LAT = 32;

   logic       clk = 1'b0;
   logic       reset;
   logic       i_imem_ready, i_dmem_ready, i_load_use, i_branch_taken;
   logic       i_mdu_start, i_mdu_is_div, i_exception;
   logic [4:0] o_stage_we, o_stage_flush;
   logic       o_mdu_busy, o_mdu_done, o_state;
`ifdef PIPE_STALL_STATS_EN
   logic [31:0] o_stall_cycles;
`endif

   int n_vec = 0;
   int n_err = 0;

   pipeline_stall_ctrl #(.MDU_MUL_LAT(MUL_LAT), .MDU_DIV_LAT(DIV_LAT), .CNT_W(6)) dut (
      .clk            (clk),
      .reset          (reset),
      .i_imem_ready   (i_imem_ready),
      .i_dmem_ready   (i_dmem_ready),
      .i_load_use     (i_load_use),
      .i_branch_taken (i_branch_taken),
      .i_mdu_start    (i_mdu_start),
      .i_mdu_is_div   (i_mdu_is_div),
      .i_exception    (i_exception),
      .o_stage_we     (o_stage_we),
      .o_stage_flush  (o_stage_flush),
      .o_mdu_busy     (o_mdu_busy),
      .o_mdu_done     (o_mdu_done),
      .o_state        (o_state)
`ifdef PIPE_STALL_STATS_EN
      ,
      .o_stall_cycles (o_stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: an MDU operation started in cycle c may release from cycle c+LAT onward
   int   cyc = 0;
   bit   m_busy = 1'b0;
   int   m_rdy = 0;
   int   m_stall = 0;

   function automatic logic [10:0] exp_out(input bit busy, input int rdy, input int c);
      bit elig;
      bit stall;
      elig  = busy && (c >= rdy);
      stall = (!busy && i_mdu_start) || (busy && !elig);
      if (i_exception)      return {5'b11111, 5'b11110, 1'b0};
      if (!i_dmem_ready)    return {5'b00000, 5'b00000, 1'b0};
      if (stall)            return {5'b11000, 5'b01000, 1'b0};
      if (i_branch_taken)   return {5'b11111, 5'b00110, elig};
      if (i_load_use)       return {5'b11100, 5'b00100, elig};
      if (!i_imem_ready)    return {5'b11110, 5'b00010, elig};
      return {5'b11111, 5'b00000, elig};
   endfunction

   always @(posedge clk) begin
      logic [10:0] e;
      e = exp_out(m_busy, m_rdy, cyc);
      if (reset) begin
         m_busy  = 1'b0;
         m_stall = 0;
      end else begin
         if (!e[6]) m_stall = m_stall + 1;
         if (i_exception) begin
            m_busy = 1'b0;
         end else if (!m_busy) begin
            if (i_mdu_start && i_dmem_ready) begin
               m_busy = 1'b1;
               m_rdy  = cyc + int'(i_mdu_is_div ? DIV_LAT : MUL_LAT);
            end
         end else if (cyc >= m_rdy && i_dmem_ready) begin
            m_busy = 1'b0;
         end
      end
      cyc = cyc + 1;
   end

   function automatic logic [12:0] dut_tuple();
      return {o_stage_we, o_stage_flush, o_mdu_busy, o_mdu_done, o_state};
   endfunction

   task automatic cmp(input string name, input logic [12:0] got, input logic [12:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got we/fl/busy/done/state=%b expected %b (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic chk_model(input string name);
      logic [10:0] e;
      e = exp_out(m_busy, m_rdy, cyc);
      cmp({name, "_model"}, dut_tuple(), {e[10:1], m_busy, e[0], m_busy});
`ifdef PIPE_STALL_STATS_EN
      n_vec++;
      if (o_stall_cycles !== 32'(m_stall)) begin
         n_err++;
         $display("FAIL %s_stats: got %0d expected %0d", name, o_stall_cycles, m_stall);
      end
`endif
   endtask

   task automatic drive(input bit r, input bit im, input bit dm, input bit lu,
                        input bit br, input bit st, input bit dv, input bit ex);
      reset = r; i_imem_ready = im; i_dmem_ready = dm; i_load_use = lu;
      i_branch_taken = br; i_mdu_start = st; i_mdu_is_div = dv; i_exception = ex;
   endtask

   // One cycle with literal expectations plus the model check, ending 1 time unit after the next edge
   task automatic step(input string name, input bit r, input bit im, input bit dm, input bit lu,
                       input bit br, input bit st, input bit dv, input bit ex,
                       input logic [4:0] we, input logic [4:0] fl, input bit busy, input bit done);
      drive(r, im, dm, lu, br, st, dv, ex);
      #1;
      cmp(name, dut_tuple(), {we, fl, busy, done, busy});
      chk_model(name);
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      string      name;
      bit         r, im, dm, lu, br, st, dv, ex;
      logic [4:0] we, fl;
      bit         busy, done;
   } vec_t;

   vec_t tbl[16];

   initial begin
      tbl[0]  = '{"reset0",        1,1,1,0,0,0,0,0, 5'b11111, 5'b00000, 0, 0};
      tbl[1]  = '{"reset1",        1,1,1,0,0,0,0,0, 5'b11111, 5'b00000, 0, 0};
      tbl[2]  = '{"idle",          0,1,1,0,0,0,0,0, 5'b11111, 5'b00000, 0, 0};
      tbl[3]  = '{"br_lu",         0,1,1,1,1,0,0,0, 5'b11111, 5'b00110, 0, 0};
      tbl[4]  = '{"lu",            0,1,1,1,0,0,0,0, 5'b11100, 5'b00100, 0, 0};
      tbl[5]  = '{"imem_wait",     0,0,1,0,0,0,0,0, 5'b11110, 5'b00010, 0, 0};
      tbl[6]  = '{"dmem_br",       0,1,0,0,1,0,0,0, 5'b00000, 5'b00000, 0, 0};
      tbl[7]  = '{"exc_dmem_lu",   0,1,0,1,0,0,0,1, 5'b11111, 5'b11110, 0, 0};
      tbl[8]  = '{"lu_imem",       0,0,1,1,0,0,0,0, 5'b11100, 5'b00100, 0, 0};
      tbl[9]  = '{"br_imem",       0,0,1,0,1,0,0,0, 5'b11111, 5'b00110, 0, 0};
      tbl[10] = '{"reset_start",   1,1,1,0,0,1,0,0, 5'b11000, 5'b01000, 0, 0};
      tbl[11] = '{"after_rst_st",  0,1,1,0,0,0,0,0, 5'b11111, 5'b00000, 0, 0};
      tbl[12] = '{"exc_start",     0,1,1,0,0,1,1,1, 5'b11111, 5'b11110, 0, 0};
      tbl[13] = '{"after_exc_st",  0,1,1,0,0,0,0,0, 5'b11111, 5'b00000, 0, 0};
      tbl[14] = '{"dmem_start",    0,1,0,0,0,1,0,0, 5'b00000, 5'b00000, 0, 0};
      tbl[15] = '{"after_dm_st",   0,1,1,0,0,0,0,0, 5'b11111, 5'b00000, 0, 0};

      drive(1, 1, 1, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;

      foreach (tbl[i])
         step(tbl[i].name, tbl[i].r, tbl[i].im, tbl[i].dm, tbl[i].lu, tbl[i].br,
              tbl[i].st, tbl[i].dv, tbl[i].ex, tbl[i].we, tbl[i].fl, tbl[i].busy, tbl[i].done);

      // Multiply: 4 stalled cycles, done on the 5th
      step("mul_start", 0,1,1,0,0,1,0,0, 5'b11000, 5'b01000, 0, 0);
      for (int k = 1; k < int'(MUL_LAT); k++)
         step("mul_wait", 0,1,1,0,0,1,0,0, 5'b11000, 5'b01000, 1, 0);
      step("mul_done",  0,1,1,0,0,0,0,0, 5'b11111, 5'b00000, 1, 1);
      step("mul_after", 0,1,1,0,0,0,0,0, 5'b11111, 5'b00000, 0, 0);

      // Divide: 32 stalled cycles
      step("div_start", 0,1,1,0,0,1,1,0, 5'b11000, 5'b01000, 0, 0);
      for (int k = 1; k < int'(DIV_LAT); k++)
         step("div_wait", 0,1,1,0,0,1,0,0, 5'b11000, 5'b01000, 1, 0);
      step("div_done",  0,1,1,0,0,0,0,0, 5'b11111, 5'b00000, 1, 1);
      step("div_after", 0,1,1,0,0,0,0,0, 5'b11111, 5'b00000, 0, 0);

      // Exception aborts a divide when its countdown reads 10
      step("abort_start", 0,1,1,0,0,1,1,0, 5'b11000, 5'b01000, 0, 0);
      for (int k = 1; k < 22; k++)
         step("abort_wait", 0,1,1,0,0,0,0,0, 5'b11000, 5'b01000, 1, 0);
      step("abort_exc",   0,1,1,0,0,0,0,1, 5'b11111, 5'b11110, 1, 0);
      step("abort_next",  0,1,1,0,0,0,0,0, 5'b11111, 5'b00000, 0, 0);
      step("abort_next2", 0,1,1,0,0,0,0,0, 5'b11111, 5'b00000, 0, 0);

      // Dmem freeze while the timer has expired delays the done pulse
      step("frz_start", 0,1,1,0,0,1,0,0, 5'b11000, 5'b01000, 0, 0);
      for (int k = 1; k < int'(MUL_LAT); k++)
         step("frz_wait", 0,1,1,0,0,0,0,0, 5'b11000, 5'b01000, 1, 0);
      for (int k = 0; k < 3; k++)
         step("frz_hold", 0,1,0,0,0,0,0,0, 5'b00000, 5'b00000, 1, 0);
      step("frz_done",  0,1,1,0,0,0,0,0, 5'b11111, 5'b00000, 1, 1);
      step("frz_after", 0,1,1,0,0,0,0,0, 5'b11111, 5'b00000, 0, 0);

`ifdef PIPE_STALL_STATS_EN
      // One multiply + one load-use + two imem waits
      step("st_rst", 1,1,1,0,0,0,0,0, 5'b11111, 5'b00000, 0, 0);
      step("st_mul", 0,1,1,0,0,1,0,0, 5'b11000, 5'b01000, 0, 0);
      for (int k = 1; k < int'(MUL_LAT); k++)
         step("st_wait", 0,1,1,0,0,0,0,0, 5'b11000, 5'b01000, 1, 0);
      step("st_done", 0,1,1,0,0,0,0,0, 5'b11111, 5'b00000, 1, 1);
      step("st_lu",   0,1,1,1,0,0,0,0, 5'b11100, 5'b00100, 0, 0);
      step("st_im0",  0,0,1,0,0,0,0,0, 5'b11110, 5'b00010, 0, 0);
      step("st_im1",  0,0,1,0,0,0,0,0, 5'b11110, 5'b00010, 0, 0);
      n_vec++;
      if (o_stall_cycles !== 32'd7) begin
         n_err++;
         $display("FAIL stall_count: got %0d expected 7", o_stall_cycles);
      end
`endif

      // Randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         drive($urandom_range(99) == 0,
               $urandom_range(99) < 80,
               $urandom_range(99) < 85,
               $urandom_range(99) < 15,
               $urandom_range(99) < 15,
               $urandom_range(99) < 20,
               $urandom_range(99) < 30,
               $urandom_range(99) < 3);
         #1;
         chk_model("rand");
         @(posedge clk);
         #1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
